// File: rtl/riscv_imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator: major opcodes and format codes.
package riscv_imm_gen_pipe_pkg;

  localparam logic [6:0] OPC_OP         = 7'b0110011;
  localparam logic [6:0] OPC_OP_32      = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

endpackage

// File: rtl/riscv_imm_decode.sv
// Combinational instruction format decoder and sign-extended immediate builder.
module riscv_imm_decode
  import riscv_imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  // Every immediate has its sign in instr[31], so a 32-bit signed form is
  // built first and then widened to XLEN with sign extension.
  logic signed [31:0] imm32;
  fmt_e               fmt_sel;

  // Select format and assemble the 32-bit immediate from the opcode.
  always_comb begin
    imm32   = '0;
    fmt_sel = FMT_NONE;
    case (instr[6:0])
      OPC_OP: fmt_sel = FMT_R;
      OPC_OP_32: begin
        if (XLEN == 64) fmt_sel = FMT_R;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt_sel = FMT_I;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt_sel = FMT_I;
          imm32   = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        fmt_sel = FMT_S;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt_sel = FMT_B;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_sel = FMT_U;
        imm32   = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_sel = FMT_J;
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
      end
      default: ;
    endcase
    // Compressed-encoding space is never a legal 32-bit instruction.
    if (instr[1:0] != 2'b11) begin
      fmt_sel = FMT_NONE;
      imm32   = '0;
    end
  end

  assign imm     = XLEN'(imm32);
  assign fmt     = fmt_sel;
  assign illegal = (fmt_sel == FMT_NONE);

endmodule

// File: rtl/riscv_imm_gen_pipe.sv
// Pipelined immediate generator: decode, registered output with a one-entry
// skid buffer for full throughput under backpressure, flush, and a saturating
// illegal-opcode counter.
module riscv_imm_gen_pipe
  import riscv_imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  riscv_imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  // Output register (or_*) and skid entry (sk_*).
  logic            or_vld_q, or_vld_d;
  logic [XLEN-1:0] or_imm_q, or_imm_d;
  logic [2:0]      or_fmt_q, or_fmt_d;
  logic            or_ill_q, or_ill_d;
  logic [XLEN-1:0] or_pc_q,  or_pc_d;
  logic            sk_vld_q, sk_vld_d;
  logic [XLEN-1:0] sk_imm_q, sk_imm_d;
  logic [2:0]      sk_fmt_q, sk_fmt_d;
  logic            sk_ill_q, sk_ill_d;
  logic [XLEN-1:0] sk_pc_q,  sk_pc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic accept;
  logic retire;

  // The skid flag is a flop, so in_ready is registered.
  assign in_ready = ~sk_vld_q;
  assign accept   = in_valid & in_ready;
  assign retire   = or_vld_q & out_ready;

  // Storage steering: fill OR when it is free or draining, else park in SK.
  always_comb begin
    or_vld_d = or_vld_q;
    or_imm_d = or_imm_q;
    or_fmt_d = or_fmt_q;
    or_ill_d = or_ill_q;
    or_pc_d  = or_pc_q;
    sk_vld_d = sk_vld_q;
    sk_imm_d = sk_imm_q;
    sk_fmt_d = sk_fmt_q;
    sk_ill_d = sk_ill_q;
    sk_pc_d  = sk_pc_q;
    cnt_d    = cnt_q;
    if (flush) begin
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end else begin
      if (!or_vld_q || retire) begin
        if (sk_vld_q) begin
          // SK is older than anything arriving now; accept is blocked
          // because in_ready is low whenever SK holds an entry.
          or_vld_d = 1'b1;
          or_imm_d = sk_imm_q;
          or_fmt_d = sk_fmt_q;
          or_ill_d = sk_ill_q;
          or_pc_d  = sk_pc_q;
          sk_vld_d = 1'b0;
        end else if (accept) begin
          or_vld_d = 1'b1;
          or_imm_d = dec_imm;
          or_fmt_d = dec_fmt;
          or_ill_d = dec_ill;
          or_pc_d  = in_pc;
        end else begin
          or_vld_d = 1'b0;
        end
      end else if (accept) begin
        sk_vld_d = 1'b1;
        sk_imm_d = dec_imm;
        sk_fmt_d = dec_fmt;
        sk_ill_d = dec_ill;
        sk_pc_d  = in_pc;
      end
      if (accept && dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      or_vld_q <= 1'b0;
      or_imm_q <= '0;
      or_fmt_q <= '0;
      or_ill_q <= 1'b0;
      or_pc_q  <= '0;
      sk_vld_q <= 1'b0;
      sk_imm_q <= '0;
      sk_fmt_q <= '0;
      sk_ill_q <= 1'b0;
      sk_pc_q  <= '0;
      cnt_q    <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      or_imm_q <= or_imm_d;
      or_fmt_q <= or_fmt_d;
      or_ill_q <= or_ill_d;
      or_pc_q  <= or_pc_d;
      sk_vld_q <= sk_vld_d;
      sk_imm_q <= sk_imm_d;
      sk_fmt_q <= sk_fmt_d;
      sk_ill_q <= sk_ill_d;
      sk_pc_q  <= sk_pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = or_vld_q;
  assign out_imm     = or_imm_q;
  assign out_fmt     = or_fmt_q;
  assign out_illegal = or_ill_q;
  assign out_pc      = or_pc_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_imm_gen_pipe.sv
// Scoreboard bench: an XLEN=32/CNT_W=2 instance and an XLEN=64 instance share
// all inputs; each has its own expected-result queue and monitor.
module tb_riscv_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_pc32;
  logic [2:0]  out_fmt32;
  logic [1:0]  cnt32;

  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64, out_pc64;
  logic [2:0]  out_fmt64;
  logic [15:0] cnt64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_ill32),
    .out_pc(out_pc32), .illegal_cnt(cnt32)
  );

  riscv_imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_ill64),
    .out_pc(out_pc64), .illegal_cnt(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: a retire happens at the next rising edge when valid&&ready
  // holds mid-cycle.
  always @(negedge clk) begin
    if (out_valid32 && out_ready) begin
      if (q32.size() == 0) begin
        chk("x32_unexpected_out", 64'(out_pc32), 64'hDEAD);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("x32_imm", 64'(out_imm32), e.imm);
        chk("x32_fmt", 64'(out_fmt32), 64'(e.fmt));
        chk("x32_ill", 64'(out_ill32), 64'(e.ill));
        chk("x32_pc",  64'(out_pc32),  e.pc);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid64 && out_ready) begin
      if (q64.size() == 0) begin
        chk("x64_unexpected_out", out_pc64, 64'hDEAD);
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("x64_imm", out_imm64, e.imm);
        chk("x64_fmt", 64'(out_fmt64), 64'(e.fmt));
        chk("x64_ill", 64'(out_ill64), 64'(e.ill));
        chk("x64_pc",  out_pc64, e.pc);
      end
    end
  end

  // Present one instruction and wait (bounded) for acceptance; expected
  // results are queued only if the accept is not flushed.
  task automatic send(input logic [31:0] instr, input logic [63:0] pc,
                      input logic [31:0] i32, input logic [2:0] f32,
                      input logic [63:0] i64, input logic [2:0] f64);
    int t;
    exp_t e;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    t = 0;
    while (!in_ready32 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready32) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: pc %h not accepted, in_ready=%b required 1", pc, in_ready32);
    end else begin
      if (!flush) begin
        e.imm = 64'(i32); e.fmt = f32; e.ill = (f32 == 3'd7); e.pc = 64'(pc[31:0]);
        q32.push_back(e);
        e.imm = i64; e.fmt = f64; e.ill = (f64 == 3'd7); e.pc = pc;
        q64.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q32.size() != 0 || q64.size() != 0) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q32.delete();
    q64.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_out_valid", 64'(out_valid32), 0);
    chk("rst_in_ready",  64'(in_ready32), 1);
    chk("rst_out_imm",   64'(out_imm32), 0);
    chk("rst_out_fmt",   64'(out_fmt32), 0);
    chk("rst_out_ill",   64'(out_ill32), 0);
    chk("rst_out_pc",    64'(out_pc32), 0);
    chk("rst_cnt32",     64'(cnt32), 0);
    chk("rst_out_valid64", 64'(out_valid64), 0);
    chk("rst_cnt64",     64'(cnt64), 0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Formats and immediates
    send(32'hFFF00093, 64'hA000_0000_0000_1000, 32'hFFFFFFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    chk("latency_out_valid", 64'(out_valid32), 1);
    send(32'h7FF00093, 64'h1004, 32'h000007FF, 3'd1, 64'h0000_0000_0000_07FF, 3'd1);
    send(32'hFE112E23, 64'h1008, 32'hFFFFFFFC, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2);
    send(32'hFE000CE3, 64'h100C, 32'hFFFFFFF8, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3);
    send(32'h800000B7, 64'h1010, 32'h80000000, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4);
    send(32'h0010006F, 64'h1014, 32'h00000800, 3'd5, 64'h0000_0000_0000_0800, 3'd5);
    send(32'h0000001B, 64'h1018, 32'h0, 3'd7, 64'h0, 3'd1);
    send(32'h002081B3, 64'h101C, 32'h0, 3'd0, 64'h0, 3'd0);
    send(32'h0000003B, 64'h1020, 32'h0, 3'd7, 64'h0, 3'd0);
    drain();

    // Backpressure: A in OR, B in SK, C held until the output drains
    out_ready = 1'b0;
    send(32'h002081B3, 64'h8000_0000_0000_0100, 32'h0, 3'd0, 64'h0, 3'd0);
    send(32'hFFF00093, 64'h0104, 32'hFFFFFFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    chk("bp_in_ready_low", 64'(in_ready32), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_out_valid_held", 64'(out_valid32), 1);
    chk("bp_out_pc_stable",  64'(out_pc32), 64'h0100);
    chk("bp_out_imm_stable", 64'(out_imm32), 0);
    fork
      begin
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join_none
    send(32'h800000B7, 64'h0108, 32'h80000000, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4);
    drain();

    // Flush with OR and SK full
    do_reset();
    reset_n   = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(32'h002081B3, 64'h0200, 32'h0, 3'd0, 64'h0, 3'd0);
    send(32'h002081B3, 64'h0204, 32'h0, 3'd0, 64'h0, 3'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q32.delete();
    q64.delete();
    chk("flush_out_valid", 64'(out_valid32), 0);
    chk("flush_in_ready",  64'(in_ready32), 1);

    // An illegal accepted in a flush cycle is dropped and not counted
    out_ready = 1'b1;
    flush = 1'b1;
    send(32'h00000000, 64'h0300, 32'h0, 3'd7, 64'h0, 3'd7);
    flush = 1'b0;
    chk("flush_accept_dropped", 64'(out_valid32), 0);
    chk("flush_accept_cnt", 64'(cnt32), 0);

    // Illegal counter and saturation
    for (int i = 0; i < 3; i++) begin
      send(32'h00000000, 64'h0400 + 64'(4 * i), 32'h0, 3'd7, 64'h0, 3'd7);
    end
    drain();
    chk("cnt32_three", 64'(cnt32), 3);
    chk("cnt64_three", 64'(cnt64), 3);
    send(32'h00000000, 64'h0410, 32'h0, 3'd7, 64'h0, 3'd7);
    drain();
    chk("cnt32_saturated", 64'(cnt32), 3);
    chk("cnt64_four",      64'(cnt64), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
